// File: rtl/text_line_fetcher.sv
// Purpose : character buffer + per-scan-line font fetch sequencer + 1 px/clk line streamer.
// Latency : fetch occupies NUM_CHARS+1 cycles after line_start; pixel_on is 1 cycle after pix_x.
// Backpr. : none; a line_start during a fetch is dropped and flagged in sticky o_overrun.
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_wr_en/i_wr_idx/i_wr_char text buffer write (ASCII code into cell)
//   i_clr                     fill text buffer with spaces, clear overrun
//   i_line_start, i_line_y    hblank start pulse and the line about to be shown
//   i_pix_active, i_pix_x     active video qualifier and column
//   o_font_char_code/o_font_row  font_rom address; i_font_line returns 1 cycle later
//   o_pixel_on, o_busy, o_overrun  pixel out, fetch in progress, sticky overrun
module text_line_fetcher #(
    parameter int NUM_CHARS = 16,
    parameter int TEXT_Y0   = 0,
    localparam int IW       = $clog2(NUM_CHARS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_idx,
    input  logic [7:0]    i_wr_char,
    input  logic          i_clr,
    input  logic          i_line_start,
    input  logic [9:0]    i_line_y,
    input  logic          i_pix_active,
    input  logic [9:0]    i_pix_x,
    output logic [7:0]    o_font_char_code,
    output logic [3:0]    o_font_row,
    input  logic [7:0]    i_font_line,
    output logic          o_pixel_on,
    output logic          o_busy,
    output logic          o_overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [7:0]    r_text    [NUM_CHARS];
    logic [7:0]    r_linebuf [NUM_CHARS];
    logic          r_blank   [NUM_CHARS];
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_idx_d;
    logic          r_cap_vld;
    logic [2:0]    r_row;
    logic          r_band_valid;
    logic          r_busy;
    logic          r_overrun;

    logic          w_start;
    logic          w_reject;
    logic          w_issue;
    logic          w_done;
    logic [9:0]    w_rel;
    logic [7:0]    w_code;
    logic          w_blank;
    logic          w_pix_in;
    logic [IW-1:0] w_cell;
    logic [2:0]    w_bit;

    // Unsigned wrap makes lines above the band look far away, so one compare suffices.
    assign w_rel    = i_line_y - 10'(TEXT_Y0);
    assign w_code   = r_text[r_idx];
    assign w_blank  = (w_code == 8'd32) || w_code[7];
    assign w_pix_in = i_pix_x < 10'(NUM_CHARS * 8);
    assign w_cell   = i_pix_x[IW+2:3];
    assign w_bit    = 3'd7 - i_pix_x[2:0];

    assign o_busy    = r_busy;
    assign o_overrun = r_overrun;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_reject    = 1'b0;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_line_start) begin
                    if (w_rel < 10'd8) begin
                        w_start     = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_reject    = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                w_issue = 1'b1;
                if (r_idx == IW'(NUM_CHARS - 1)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                r_text[i]    <= 8'd32;
                r_linebuf[i] <= 8'h00;
                r_blank[i]   <= 1'b0;
            end
            r_idx            <= '0;
            r_idx_d          <= '0;
            r_cap_vld        <= 1'b0;
            r_row            <= 3'd0;
            r_band_valid     <= 1'b0;
            r_busy           <= 1'b0;
            r_overrun        <= 1'b0;
            o_font_char_code <= 8'd0;
            o_font_row       <= 4'd0;
            o_pixel_on       <= 1'b0;
        end else begin
            if (i_clr) begin
                for (int i = 0; i < NUM_CHARS; i++) r_text[i] <= 8'd32;
            end else if (i_wr_en) begin
                r_text[i_wr_idx] <= i_wr_char;
            end

            if (w_start) begin
                r_row  <= w_rel[2:0];
                r_idx  <= '0;
                r_busy <= 1'b1;
            end
            if (w_reject) r_band_valid <= 1'b0;

            // Codes >= 128 have no glyph; fetch a space and force the cell blank.
            if (w_issue) begin
                o_font_char_code <= w_code[7] ? 8'd32 : w_code;
                o_font_row       <= {1'b0, r_row};
                r_blank[r_idx]   <= w_blank;
                r_idx            <= r_idx + IW'(1);
            end

            // font_line answers the address registered on the previous edge.
            r_cap_vld <= w_issue;
            r_idx_d   <= r_idx;
            if (r_cap_vld) r_linebuf[r_idx_d] <= r_blank[r_idx_d] ? 8'h00 : i_font_line;

            if (w_done) begin
                r_band_valid <= 1'b1;
                r_busy       <= 1'b0;
            end

            if (i_clr)                       r_overrun <= 1'b0;
            else if (i_line_start && r_busy) r_overrun <= 1'b1;

            o_pixel_on <= i_pix_active && r_band_valid && w_pix_in && r_linebuf[w_cell][w_bit];
        end
    end

endmodule

// File: tb/tb_text_line_fetcher.sv
module tb_text_line_fetcher;

    localparam int NC = 16;
    localparam int Y0 = 0;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_wr_en;
    logic [3:0] i_wr_idx;
    logic [7:0] i_wr_char;
    logic       i_clr;
    logic       i_line_start;
    logic [9:0] i_line_y;
    logic       i_pix_active;
    logic [9:0] i_pix_x;
    logic [7:0] o_font_char_code;
    logic [3:0] o_font_row;
    logic [7:0] i_font_line;
    logic       o_pixel_on;
    logic       o_busy;
    logic       o_overrun;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] tm     [NC];
    logic [7:0] m_lbuf [NC];
    logic       m_band;
    logic       m_ovr;

    text_line_fetcher #(.NUM_CHARS(NC), .TEXT_Y0(Y0)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_wr_en(i_wr_en), .i_wr_idx(i_wr_idx), .i_wr_char(i_wr_char),
        .i_clr(i_clr), .i_line_start(i_line_start), .i_line_y(i_line_y),
        .i_pix_active(i_pix_active), .i_pix_x(i_pix_x),
        .o_font_char_code(o_font_char_code), .o_font_row(o_font_row),
        .i_font_line(i_font_line), .o_pixel_on(o_pixel_on),
        .o_busy(o_busy), .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    // Stand-in font ROM: combinational on the registered address.
    function automatic logic [7:0] font_fn(input logic [7:0] c, input logic [3:0] r);
        if (c == 8'd49 && r == 4'd1) return 8'h38;
        if (c == 8'd43 && r == 4'd3) return 8'hFF;
        return (c * 8'd37) ^ {r, r} ^ 8'h5A;
    endfunction

    assign i_font_line = font_fn(o_font_char_code, o_font_row);

    function automatic logic exp_pix(input int x, input logic act);
        if (!act || !m_band || x >= NC * 8) return 1'b0;
        return m_lbuf[x / 8][7 - (x % 8)];
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            tm[i]     = 8'd32;
            m_lbuf[i] = 8'h00;
        end
        m_band = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic wr(input int idx, input logic [7:0] ch);
        i_wr_en   = 1'b1;
        i_wr_idx  = 4'(idx);
        i_wr_char = ch;
        tick();
        i_wr_en   = 1'b0;
        tm[idx]   = ch;
    endtask

    // Issue one line_start and follow the whole fetch; inj >= 0 pulses a
    // second line_start on that busy cycle.
    task automatic do_line(input logic [9:0] y, input int inj);
        logic [9:0] rel;
        logic       inband;
        logic [7:0] snap [NC];
        int         n;
        rel    = y - 10'(Y0);
        inband = (rel < 10'd8);
        for (int c = 0; c < NC; c++) snap[c] = tm[c];
        i_line_start = 1'b1;
        i_line_y     = y;
        tick();
        i_line_start = 1'b0;
        n = 0;
        while (o_busy === 1'b1 && n < 40) begin
            if (n >= 1 && n <= NC) begin
                chk($sformatf("code_c%0d", n - 1), 32'(o_font_char_code),
                    32'((snap[n-1] >= 8'd128) ? 8'd32 : snap[n-1]));
                chk($sformatf("row_c%0d", n - 1), 32'(o_font_row), 32'({1'b0, rel[2:0]}));
            end
            if (n == inj) begin
                i_line_start = 1'b1;
                i_line_y     = y + 10'd4;
                m_ovr        = 1'b1;
            end
            tick();
            i_line_start = 1'b0;
            n++;
        end
        chk($sformatf("busy_len_y%0d", y), 32'(n), inband ? 32'(NC + 1) : 32'd0);
        if (inband) begin
            m_band = 1'b1;
            for (int c = 0; c < NC; c++)
                m_lbuf[c] = (snap[c] == 8'd32 || snap[c] >= 8'd128) ? 8'h00
                                                                    : font_fn(snap[c], {1'b0, rel[2:0]});
        end else begin
            m_band = 1'b0;
        end
        chk("overrun", 32'(o_overrun), 32'(m_ovr));
    endtask

    task automatic sweep(input int x0, input int x1, input logic act);
        for (int x = x0; x <= x1; x++) begin
            i_pix_x      = 10'(x);
            i_pix_active = act;
            tick();
            chk($sformatf("pix_x%0d", x), 32'(o_pixel_on), 32'(exp_pix(x, act)));
        end
        i_pix_active = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_wr_en = 1'b0; i_wr_idx = 4'd0; i_wr_char = 8'd0;
        i_clr = 1'b0; i_line_start = 1'b0; i_line_y = 10'd0;
        i_pix_active = 1'b0; i_pix_x = 10'd0;
        model_reset();
        tick(); tick(); tick();
        i_rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_overrun", 32'(o_overrun), 32'd0);
        chk("rst_pixel", 32'(o_pixel_on), 32'd0);
        chk("rst_code", 32'(o_font_char_code), 32'd0);
        chk("rst_row", 32'(o_font_row), 32'd0);

        // 1: all spaces, no pixels
        do_line(10'(Y0 + 3), -1);
        sweep(0, 127, 1'b1);

        // 2: '1' in cell 0, row 1 -> 0,0,1,1,1,0,0,0
        wr(0, 8'd49);
        do_line(10'(Y0 + 1), -1);
        sweep(0, 9, 1'b1);

        // 3: '+' in cell 15, row 3; right edge and one past it
        wr(15, 8'd43);
        do_line(10'(Y0 + 3), -1);
        sweep(118, 129, 1'b1);
        sweep(120, 127, 1'b0);

        // 4: lines below and above the band
        do_line(10'(Y0 + 8), -1);
        sweep(0, 7, 1'b1);
        do_line(10'(Y0 - 1), -1);
        sweep(120, 127, 1'b1);

        // 5: overrun, fetch unaffected, clr beats a same-cycle write
        wr(7, 8'd77);
        do_line(10'(Y0 + 2), 5);
        sweep(0, 127, 1'b1);
        i_clr = 1'b1; i_wr_en = 1'b1; i_wr_idx = 4'd5; i_wr_char = 8'd65;
        tick();
        i_clr = 1'b0; i_wr_en = 1'b0;
        for (int i = 0; i < NC; i++) tm[i] = 8'd32;
        m_ovr = 1'b0;
        chk("clr_overrun", 32'(o_overrun), 32'd0);
        do_line(10'(Y0 + 4), -1);
        sweep(0, 127, 1'b1);

        // 6: high code forced blank
        wr(2, 8'd65);
        wr(3, 8'd200);
        wr(4, 8'd66);
        do_line(10'(Y0 + 5), -1);
        sweep(16, 39, 1'b1);

        // Randomized writes, lines and pixel probes
        for (int it = 0; it < 12; it++) begin
            int nw;
            logic [9:0] y;
            nw = int'($urandom_range(1, 4));
            for (int k = 0; k < nw; k++) begin
                int idx;
                logic [7:0] ch;
                idx = int'($urandom_range(0, NC - 1));
                case ($urandom % 4)
                    0:       ch = 8'd32;
                    1:       ch = 8'($urandom_range(128, 255));
                    default: ch = 8'($urandom_range(33, 127));
                endcase
                wr(idx, ch);
            end
            y = ($urandom % 6 == 0) ? 10'd1023 : 10'($urandom_range(0, 11) + Y0);
            do_line(y, -1);
            for (int k = 0; k < 24; k++) begin
                int x;
                logic act;
                x   = int'($urandom_range(0, 140));
                act = ($urandom % 4) != 0;
                sweep(x, x, act);
            end
        end

        // Reset dropped mid-fetch (overrun set first)
        wr(1, 8'd70);
        i_line_start = 1'b1; i_line_y = 10'(Y0 + 6);
        tick();
        i_line_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) i_line_start = 1'b1;
            tick();
            i_line_start = 1'b0;
        end
        chk("pre_rst_busy", 32'(o_busy), 32'd1);
        chk("pre_rst_overrun", 32'(o_overrun), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_overrun", 32'(o_overrun), 32'd0);
        chk("mid_rst_code", 32'(o_font_char_code), 32'd0);
        chk("mid_rst_row", 32'(o_font_row), 32'd0);
        chk("mid_rst_pixel", 32'(o_pixel_on), 32'd0);
        tick();
        i_rst_n = 1'b1;
        model_reset();
        tick();
        sweep(0, 15, 1'b1);
        do_line(10'(Y0 + 0), -1);
        sweep(0, 15, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
